// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic light monitor: lamp encodings,
// fault codes, road indices and the per-road check flag bundle.
package traffic_pkg;

    // Lamp code is {R,Y,G}; exactly one bit set is a legal lamp.
    localparam logic [2:0] LAMP_RED = 3'b100;
    localparam logic [2:0] LAMP_YEL = 3'b010;
    localparam logic [2:0] LAMP_GRN = 3'b001;

    // Fault codes; a lower value has higher priority within a cycle.
    localparam logic [3:0] FC_NONE     = 4'd0;
    localparam logic [3:0] FC_CONFLICT = 4'd1;
    localparam logic [3:0] FC_ENC      = 4'd2;
    localparam logic [3:0] FC_SEQ      = 4'd3;
    localparam logic [3:0] FC_SHORT_G  = 4'd4;
    localparam logic [3:0] FC_SHORT_Y  = 4'd5;
    localparam logic [3:0] FC_STUCK    = 4'd6;

    // Road indices as reported on fault_road.
    localparam logic [1:0] ROAD_M1 = 2'd0;
    localparam logic [1:0] ROAD_M2 = 2'd1;
    localparam logic [1:0] ROAD_MT = 2'd2;
    localparam logic [1:0] ROAD_S  = 2'd3;

    // Per-road check results, all combinational for the current sample.
    typedef struct packed {
        logic enc;
        logic seq;
        logic short_g;
        logic short_y;
        logic stuck;
    } lamp_flags_t;

    // True when the lamp code is one of RED, YEL or GRN.
    function automatic logic lamp_legal(input logic [2:0] lamp);
        return (lamp == LAMP_RED) || (lamp == LAMP_YEL) || (lamp == LAMP_GRN);
    endfunction

endpackage

// File: rtl/traffic_light_monitor_lamp_checker.sv
// Single-road lamp checker: tracks the previous lamp, how many consecutive
// samples it has been shown, and flags encoding, ordering and dwell faults
// for the lamp presented on the current clock edge.
module lamp_checker
    import traffic_pkg::*;
#(
    parameter int MIN_GREEN  = 3,
    parameter int MIN_YELLOW = 2,
    parameter int MAX_PHASE  = 15,
    parameter int CNT_W      = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  lamp,
    output lamp_flags_t flags
);

    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] MIN_G_C   = CNT_W'(MIN_GREEN);
    localparam logic [CNT_W-1:0] MIN_Y_C   = CNT_W'(MIN_YELLOW);
    localparam logic [CNT_W-1:0] MAX_PH_C  = CNT_W'(MAX_PHASE);

    logic [2:0]       prev_q, prev_d;
    logic [CNT_W-1:0] dwell_q, dwell_d;
    logic             prev_valid_q, prev_valid_d;
    // Set once a real transition has been seen; until then the dwell of the
    // previous lamp may be truncated by reset, so SHORT checks are held off.
    logic             armed_q, armed_d;
    logic             changed;
    logic             legal_step;

    // Next-state for previous lamp, dwell counter and the valid/armed bits.
    always_comb begin
        changed      = prev_valid_q && (lamp != prev_q);
        prev_d       = lamp;
        prev_valid_d = 1'b1;
        armed_d      = armed_q | changed;
        if (!prev_valid_q || changed) begin
            dwell_d = CNT_ONE;
        end else if (dwell_q != CNT_MAX) begin
            dwell_d = dwell_q + CNT_ONE;
        end else begin
            dwell_d = dwell_q;
        end
    end

    // Check flags for the current sample against the stored history.
    // STUCK is not gated by armed: a dwell truncated by reset can only
    // undercount, so it never causes a false STUCK.
    always_comb begin
        flags      = '0;
        legal_step = (lamp == prev_q) ||
                     ((prev_q == LAMP_GRN) && (lamp == LAMP_YEL)) ||
                     ((prev_q == LAMP_YEL) && (lamp == LAMP_RED)) ||
                     ((prev_q == LAMP_RED) && (lamp == LAMP_GRN));
        flags.enc     = !lamp_legal(lamp);
        flags.seq     = prev_valid_q && !legal_step;
        flags.short_g = armed_q && (prev_q == LAMP_GRN) && (lamp == LAMP_YEL) &&
                        (dwell_q < MIN_G_C);
        flags.short_y = armed_q && (prev_q == LAMP_YEL) && (lamp == LAMP_RED) &&
                        (dwell_q < MIN_Y_C);
        flags.stuck   = (lamp != LAMP_RED) && (dwell_d >= MAX_PH_C);
    end

    // History registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q       <= LAMP_RED;
            dwell_q      <= '0;
            prev_valid_q <= 1'b0;
            armed_q      <= 1'b0;
        end else begin
            prev_q       <= prev_d;
            dwell_q      <= dwell_d;
            prev_valid_q <= prev_valid_d;
            armed_q      <= armed_d;
        end
    end

endmodule

// File: rtl/traffic_light_monitor.sv
// Safety observer for the four lamp buses of the traffic light controller.
// Combines per-road checks with cross-road conflict detection, latches the
// first fault (code and road), counts violating cycles and requests flash.
module traffic_light_monitor
    import traffic_pkg::*;
#(
    parameter int MIN_GREEN  = 3,
    parameter int MIN_YELLOW = 2,
    parameter int MAX_PHASE  = 15,
    parameter int CNT_W      = 4,
    parameter int ERR_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       light_M1,
    input  logic [2:0]       light_M2,
    input  logic [2:0]       light_MT,
    input  logic [2:0]       light_S,
    input  logic             clr_fault,
    output logic             fault,
    output logic [3:0]       fault_code,
    output logic [1:0]       fault_road,
    output logic [ERR_W-1:0] err_count,
    output logic             flash_req
);

    logic [2:0]  lamps [4];
    lamp_flags_t flags [4];

    assign lamps[0] = light_M1;
    assign lamps[1] = light_M2;
    assign lamps[2] = light_MT;
    assign lamps[3] = light_S;

    for (genvar r = 0; r < 4; r++) begin : g_chk
        lamp_checker #(
            .MIN_GREEN  (MIN_GREEN),
            .MIN_YELLOW (MIN_YELLOW),
            .MAX_PHASE  (MAX_PHASE),
            .CNT_W      (CNT_W)
        ) u_chk (
            .clk   (clk),
            .rst   (rst),
            .lamp  (lamps[r]),
            .flags (flags[r])
        );
    end

    // Lowest road index with its bit set in the mask.
    function automatic logic [1:0] first_road(input logic [3:0] m);
        logic [1:0] idx;
        idx = 2'd0;
        for (int r = 3; r >= 0; r--) begin
            if (m[r]) idx = 2'(r);
        end
        return idx;
    endfunction

    logic [3:0] enc_m, seq_m, shg_m, shy_m, stk_m;
    logic       conflict;
    logic [3:0] viol_code;
    logic [1:0] viol_road;
    logic       any_viol;

    // Gather per-road flags into per-check masks.
    always_comb begin
        enc_m = '0;
        seq_m = '0;
        shg_m = '0;
        shy_m = '0;
        stk_m = '0;
        for (int r = 0; r < 4; r++) begin
            enc_m[r] = flags[r].enc;
            seq_m[r] = flags[r].seq;
            shg_m[r] = flags[r].short_g;
            shy_m[r] = flags[r].short_y;
            stk_m[r] = flags[r].stuck;
        end
    end

    // Cross-road conflict and priority encoding of this cycle's violation.
    // M1 with MT is a protected pairing and is not a conflict.
    always_comb begin
        conflict = ((light_S != LAMP_RED) &&
                    ((light_M1 != LAMP_RED) || (light_M2 != LAMP_RED) ||
                     (light_MT != LAMP_RED))) ||
                   ((light_M2 != LAMP_RED) && (light_MT != LAMP_RED));
        viol_code = FC_NONE;
        viol_road = ROAD_M1;
        if (conflict) begin
            viol_code = FC_CONFLICT;
            viol_road = ROAD_S;
        end else if (|enc_m) begin
            viol_code = FC_ENC;
            viol_road = first_road(enc_m);
        end else if (|seq_m) begin
            viol_code = FC_SEQ;
            viol_road = first_road(seq_m);
        end else if (|shg_m) begin
            viol_code = FC_SHORT_G;
            viol_road = first_road(shg_m);
        end else if (|shy_m) begin
            viol_code = FC_SHORT_Y;
            viol_road = first_road(shy_m);
        end else if (|stk_m) begin
            viol_code = FC_STUCK;
            viol_road = first_road(stk_m);
        end
        any_viol = (viol_code != FC_NONE);
    end

    logic             fault_q, fault_d;
    logic [3:0]       code_q, code_d;
    logic [1:0]       road_q, road_d;
    logic [ERR_W-1:0] err_q, err_d;

    // Fault latch: first violation sticks; a clear on a violating cycle
    // re-latches the new violation instead of dropping it.
    always_comb begin
        fault_d = fault_q;
        code_d  = code_q;
        road_d  = road_q;
        if (clr_fault || !fault_q) begin
            fault_d = any_viol;
            code_d  = any_viol ? viol_code : FC_NONE;
            road_d  = any_viol ? viol_road : ROAD_M1;
        end
        err_d = err_q;
        if (any_viol && (err_q != {ERR_W{1'b1}})) begin
            err_d = err_q + ERR_W'(1);
        end
    end

    // Fault and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            fault_q <= 1'b0;
            code_q  <= FC_NONE;
            road_q  <= ROAD_M1;
            err_q   <= '0;
        end else begin
            fault_q <= fault_d;
            code_q  <= code_d;
            road_q  <= road_d;
            err_q   <= err_d;
        end
    end

    assign fault      = fault_q;
    assign fault_code = code_q;
    assign fault_road = road_q;
    assign err_count  = err_q;
    assign flash_req  = fault_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed bench for traffic_light_monitor: each step drives one cycle of
// lamp values and, when checked, queues the expected outputs which are
// popped and compared one time unit after the clock edge.
module tb_traffic_light_monitor;

    localparam logic [2:0] R = 3'b100;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] G = 3'b001;

    typedef struct packed {
        logic       fault;
        logic [3:0] code;
        logic [1:0] road;
        logic [7:0] err;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] light_M1, light_M2, light_MT, light_S;
    logic       clr_fault;
    logic       fault;
    logic [3:0] fault_code;
    logic [1:0] fault_road;
    logic [7:0] err_count;
    logic       flash_req;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Clock and DUT
    always #5 clk = ~clk;

    traffic_light_monitor dut (
        .clk        (clk),
        .rst        (rst),
        .light_M1   (light_M1),
        .light_M2   (light_M2),
        .light_MT   (light_MT),
        .light_S    (light_S),
        .clr_fault  (clr_fault),
        .fault      (fault),
        .fault_code (fault_code),
        .fault_road (fault_road),
        .err_count  (err_count),
        .flash_req  (flash_req)
    );

    function automatic exp_t mk(input logic f, input int code, input int road, input int err);
        exp_t e;
        e.fault = f;
        e.code  = 4'(code);
        e.road  = 2'(road);
        e.err   = 8'(err);
        return e;
    endfunction

    // Scoreboard comparison of the current outputs against one expectation
    task automatic compare(input string tag, input exp_t e);
        checks++;
        assert (fault === e.fault) else begin
            failures++;
            $error("FAIL %s fault got=%0b exp=%0b", tag, fault, e.fault);
        end
        checks++;
        assert (flash_req === e.fault) else begin
            failures++;
            $error("FAIL %s flash_req got=%0b exp=%0b", tag, flash_req, e.fault);
        end
        checks++;
        assert (fault_code === e.code) else begin
            failures++;
            $error("FAIL %s fault_code got=%0d exp=%0d", tag, fault_code, e.code);
        end
        checks++;
        assert (fault_road === e.road) else begin
            failures++;
            $error("FAIL %s fault_road got=%0d exp=%0d", tag, fault_road, e.road);
        end
        checks++;
        assert (err_count === e.err) else begin
            failures++;
            $error("FAIL %s err_count got=%0d exp=%0d", tag, err_count, e.err);
        end
    endtask

    // Driver: one clock cycle of stimulus, optional check after the edge
    task automatic step(input string tag, input logic r,
                        input logic [2:0] m1, input logic [2:0] m2,
                        input logic [2:0] mt, input logic [2:0] s,
                        input logic clr, input logic chk, input exp_t e);
        exp_t got;
        rst       = r;
        light_M1  = m1;
        light_M2  = m2;
        light_MT  = mt;
        light_S   = s;
        clr_fault = clr;
        if (chk) exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (chk) begin
            got = exp_q.pop_front();
            compare(tag, got);
        end
    endtask

    task automatic do_reset();
        step("rst", 1'b1, R, R, R, R, 1'b0, 1'b1, mk(0, 0, 0, 0));
    endtask

    exp_t nul;

    initial begin
        nul = mk(0, 0, 0, 0);
        rst = 1'b1;
        light_M1 = R; light_M2 = R; light_MT = R; light_S = R;
        clr_fault = 1'b0;
        do_reset();

        // 1. Legal cycle, three repetitions
        for (int rep = 0; rep < 3; rep++) begin
            for (int i = 0; i < 5; i++) step("leg", 0, G, G, R, R, 0, 0, nul);
            for (int i = 0; i < 2; i++) step("leg", 0, Y, Y, R, R, 0, 0, nul);
            for (int i = 0; i < 3; i++) step("leg", 0, R, R, G, R, 0, 0, nul);
            for (int i = 0; i < 2; i++) step("leg", 0, R, R, Y, R, 0, 0, nul);
            for (int i = 0; i < 4; i++) step("leg", 0, R, R, R, G, 0, 0, nul);
            step("leg", 0, R, R, R, Y, 0, 0, nul);
            step("legal", 0, R, R, R, Y, 0, 1, mk(0, 0, 0, 0));
        end

        // 2. Conflict S=GRN with M1=YEL
        for (int i = 0; i < 3; i++) step("pre", 0, G, R, R, R, 0, 0, nul);
        step("conflict", 0, Y, R, R, G, 0, 1, mk(1, 1, 3, 1));
        // 5. Sticky: later SEQ on M2 (and S) only counts once
        step("sticky", 0, Y, Y, R, R, 0, 1, mk(1, 1, 3, 2));
        step("clr_clean", 0, R, Y, R, R, 1, 1, mk(0, 0, 0, 2));
        step("post_clr", 0, R, R, R, R, 0, 1, mk(0, 0, 0, 2));
        step("enc_m1", 0, 3'b011, R, R, R, 0, 1, mk(1, 2, 0, 3));
        step("clr_conf", 0, R, R, G, G, 1, 1, mk(1, 1, 3, 4));

        // 3a. M2 GRN->RED directly
        do_reset();
        step("r", 0, R, R, R, R, 0, 0, nul);
        for (int i = 0; i < 3; i++) step("m2g", 0, R, G, R, R, 0, 1, nul);
        step("seq_m2", 0, R, R, R, R, 0, 1, mk(1, 3, 1, 1));

        // Tie: ENC on M1 and M2 in the same cycle, lowest road wins
        do_reset();
        step("r", 0, R, R, R, R, 0, 0, nul);
        step("enc_tie", 0, 3'b111, 3'b111, R, R, 0, 1, mk(1, 2, 0, 1));

        // 3b. MT illegal code beats its SEQ
        do_reset();
        step("r", 0, R, R, R, R, 0, 0, nul);
        step("enc_mt", 0, R, R, 3'b011, R, 0, 1, mk(1, 2, 2, 1));

        // 4a. M1 short green
        do_reset();
        step("r", 0, R, R, R, R, 0, 0, nul);
        step("g1", 0, G, R, R, R, 0, 0, nul);
        step("g2", 0, G, R, R, R, 0, 1, nul);
        step("short_g", 0, Y, R, R, R, 0, 1, mk(1, 4, 0, 1));

        // 4b. S short yellow
        do_reset();
        step("r", 0, R, R, R, R, 0, 0, nul);
        for (int i = 0; i < 3; i++) step("sg", 0, R, R, R, G, 0, 0, nul);
        step("sy", 0, R, R, R, Y, 0, 1, nul);
        step("short_y", 0, R, R, R, R, 0, 1, mk(1, 5, 3, 1));

        // 4c. M1 green held: STUCK on the 15th cycle
        do_reset();
        step("r", 0, R, R, R, R, 0, 0, nul);
        for (int i = 0; i < 16; i++) begin
            if (i == 13) step("stuck_pre", 0, G, R, R, R, 0, 1, mk(0, 0, 0, 0));
            else if (i >= 14) step("stuck", 0, G, R, R, R, 0, 1, mk(1, 6, 0, i - 13));
            else step("g", 0, G, R, R, R, 0, 0, nul);
        end

        // 6. Reset mid-fault, first sample not sequence-checked, saturation
        do_reset();
        for (int i = 0; i < 5; i++) begin
            if (i == 4) step("err5", 0, G, R, R, G, 0, 1, mk(1, 1, 3, 5));
            else step("c", 0, G, R, R, G, 0, 0, nul);
        end
        do_reset();
        step("first_yel", 0, Y, R, R, R, 0, 1, mk(0, 0, 0, 0));
        for (int i = 0; i < 300; i++) begin
            if (i == 253) step("err254", 0, Y, G, R, G, 0, 1, mk(1, 1, 3, 254));
            else if (i == 254 || i == 299) step("err_sat", 0, Y, G, R, G, 0, 1, mk(1, 1, 3, 255));
            else step("v", 0, Y, G, R, G, 0, 0, nul);
        end

        checks++;
        assert (exp_q.size() == 0) else begin
            failures++;
            $error("FAIL queue_drain got=%0d exp=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
